// File: rtl/datapath_if.sv
// datapath_if -- memory bus between the datapath and its external 8x8 memory.
//
// Signals:
//   mem_addr   3  word address presented by the datapath
//   mem_wdata  8  write data presented by the datapath
//   mem_we     1  write enable presented by the datapath
//   mem_rdata  8  asynchronous read data returned by the memory for mem_addr
//
// Modports:
//   master  the datapath side (drives address, write data and write enable)
//   slave   the memory side (returns read data)
interface datapath_if;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/datapath.sv
// datapath -- 8-bit accumulator-style datapath driven by an external control FSM.
//
// Holds the instruction register (IR), operand register OP1, the OP2/result
// register, the IO output register and a 3-bit program counter. An external
// 8x8 memory with asynchronous read is reached through the datapath_if bus.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   enir       load IR from mem_rdata
//   enrop1     load OP1 from mem_rdata
//   enrop2     load result register with ALU(OP1, mem_rdata, seloper)
//   enrio      load io_out from mem_rdata
//   enpc       increment PC (wraps 7 -> 0)
//   enmem      memory write strobe, forwarded as mem_we
//   seloper    ALU op: 00 add, 01 sub, 10 pass OP1, 11 pass operand
//   selmux     address source: 00 PC, 01 field A, 10 field B, 11 field A
//   mem        datapath_if master modport (mem_addr/mem_wdata/mem_we/mem_rdata)
//   operacion  IR[7:6], opcode for the control FSM
//   io_out     IO register contents
//   pc         program counter
//   flag_z     zero flag of the last enrop2 result
//   flag_c     carry (add) / borrow (sub) of the last enrop2 operation
//
// Configuration:
//   DATAPATH_FLAGS_EN  when defined, flag_z/flag_c are registered on every
//                      enrop2 edge; otherwise they are tied to 0.
module datapath (
    input  logic              clk,
    input  logic              rst,
    input  logic              enir,
    input  logic              enrop1,
    input  logic              enrop2,
    input  logic              enrio,
    input  logic              enpc,
    input  logic              enmem,
    input  logic [1:0]        seloper,
    input  logic [1:0]        selmux,
    datapath_if.master        mem,
    output logic [1:0]        operacion,
    output logic [7:0]        io_out,
    output logic [2:0]        pc,
    output logic              flag_z,
    output logic              flag_c
);

    logic [7:0] ir_q,  ir_d;
    logic [7:0] op1_q, op1_d;
    logic [7:0] res_q, res_d;
    logic [7:0] io_q,  io_d;
    logic [2:0] pc_q,  pc_d;
    logic [7:0] alu_result;

    // The second operand only feeds the ALU on the enrop2 edge itself, so the
    // OP2/result register keeps just the ALU result; nothing reads the raw
    // operand afterwards.

    // Address mux: 11 reuses field A so write-back lands on the first operand.
    always_comb begin
        unique case (selmux)
            2'b00:   mem.mem_addr = pc_q;
            2'b10:   mem.mem_addr = ir_q[2:0];
            default: mem.mem_addr = ir_q[5:3];
        endcase
    end

    always_comb begin
        mem.mem_wdata = (seloper == 2'b10) ? op1_q : res_q;
        mem.mem_we    = enmem;
    end

    always_comb begin
        unique case (seloper)
            2'b00:   alu_result = op1_q + mem.mem_rdata;
            2'b01:   alu_result = op1_q - mem.mem_rdata;
            2'b10:   alu_result = op1_q;
            default: alu_result = mem.mem_rdata;
        endcase
    end

    // Every strobe is independent and samples the same mem_rdata.
    always_comb begin
        ir_d  = ir_q;
        op1_d = op1_q;
        res_d = res_q;
        io_d  = io_q;
        pc_d  = pc_q;
        if (enir)   ir_d  = mem.mem_rdata;
        if (enrop1) op1_d = mem.mem_rdata;
        if (enrop2) res_d = alu_result;
        if (enrio)  io_d  = mem.mem_rdata;
        if (enpc)   pc_d  = pc_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q  <= 8'h00;
            op1_q <= 8'h00;
            res_q <= 8'h00;
            io_q  <= 8'h00;
            pc_q  <= 3'd0;
        end else begin
            ir_q  <= ir_d;
            op1_q <= op1_d;
            res_q <= res_d;
            io_q  <= io_d;
            pc_q  <= pc_d;
        end
    end

    always_comb begin
        operacion = ir_q[7:6];
        io_out    = io_q;
        pc        = pc_q;
    end

`ifdef DATAPATH_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;

    // op1 + b overflows 8 bits exactly when op1 > 255 - b, i.e. op1 > ~b,
    // which avoids a 9-bit adder whose low bits would go unused.
    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (enrop2) begin
            flag_z_d = (alu_result == 8'h00);
            unique case (seloper)
                2'b00:   flag_c_d = (op1_q > ~mem.mem_rdata);
                2'b01:   flag_c_d = (op1_q < mem.mem_rdata);
                default: flag_c_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_datapath.sv
// tb_datapath -- self-checking bench for datapath.
//
// Provides the external 8x8 memory, a behavioural model of the datapath
// state (instruction fields, operands, result, IO, PC, flags, memory) that is
// compared against the DUT on every negative clock edge, and a set of
// directed instruction sequences with literal expected values.
// DATAPATH_FLAGS_EN is honoured the same way the design honours it.
module tb_datapath;

    logic       clk;
    logic       rst;
    logic       enir, enrop1, enrop2, enrio, enpc, enmem;
    logic [1:0] seloper, selmux;
    logic [1:0] operacion;
    logic [7:0] io_out;
    logic [2:0] pc;
    logic       flag_z, flag_c;

    datapath_if bus ();

    datapath dut (
        .clk       (clk),
        .rst       (rst),
        .enir      (enir),
        .enrop1    (enrop1),
        .enrop2    (enrop2),
        .enrio     (enrio),
        .enpc      (enpc),
        .enmem     (enmem),
        .seloper   (seloper),
        .selmux    (selmux),
        .mem       (bus),
        .operacion (operacion),
        .io_out    (io_out),
        .pc        (pc),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 0;

    // External memory seen by the DUT.
    logic [7:0] tb_mem [8];
    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    // The bench memory ignores writes while reset is held so that a reset
    // with every strobe high cannot corrupt the program.
    always @(posedge clk) begin
        if (bus.mem_we && !rst) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state.
    int m_ir, m_op1, m_res, m_io, m_pc, m_z, m_c;
    int model_mem [8];

    function automatic int expAddr(input int sel);
        if (sel == 0) return m_pc;
        if (sel == 2) return m_ir % 8;
        return (m_ir / 8) % 8;
    endfunction

    function automatic int expWdata(input int op);
        return (op == 2) ? m_op1 : m_res;
    endfunction

    always @(posedge clk) begin
        int addr, rd, wd, full;
        if (rst) begin
            m_ir = 0; m_op1 = 0; m_res = 0; m_io = 0; m_pc = 0; m_z = 0; m_c = 0;
        end else begin
            addr = expAddr(int'(selmux));
            rd   = model_mem[addr];
            wd   = expWdata(int'(seloper));
            if (enrop2) begin
                case (seloper)
                    2'd0: begin full = m_op1 + rd; m_res = full % 256; m_c = (full > 255) ? 1 : 0; end
                    2'd1: begin m_res = (m_op1 - rd + 256) % 256; m_c = (m_op1 < rd) ? 1 : 0; end
                    2'd2: begin m_res = m_op1; m_c = 0; end
                    default: begin m_res = rd; m_c = 0; end
                endcase
                m_z = (m_res == 0) ? 1 : 0;
            end
            if (enir)   m_ir  = rd;
            if (enrop1) m_op1 = rd;
            if (enrio)  m_io  = rd;
            if (enpc)   m_pc  = (m_pc + 1) % 8;
            if (enmem)  model_mem[addr] = wd;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] expFlag(input int v);
`ifdef DATAPATH_FLAGS_EN
        return 8'(v);
`else
        return 8'(0 * v);
`endif
    endfunction

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("mem_addr",  8'(bus.mem_addr),  8'(expAddr(int'(selmux))));
            checkOutput("mem_wdata", bus.mem_wdata,     8'(expWdata(int'(seloper))));
            checkOutput("mem_we",    8'(bus.mem_we),    8'(enmem));
            checkOutput("operacion", 8'(operacion),     8'(m_ir / 64));
            checkOutput("io_out",    io_out,            8'(m_io));
            checkOutput("pc",        8'(pc),            8'(m_pc));
            checkOutput("flag_z",    8'(flag_z),        expFlag(m_z));
            checkOutput("flag_c",    8'(flag_c),        expFlag(m_c));
        end
    end

    task automatic loadMem(input int addr, input logic [7:0] val);
        tb_mem[addr]    = val;
        model_mem[addr] = int'(val);
    endtask

    task automatic applyStimulus(input logic r, input logic e_ir, input logic e_op1, input logic e_op2,
                                 input logic e_io, input logic e_pc, input logic e_mem,
                                 input logic [1:0] op, input logic [1:0] mx);
        rst = r; enir = e_ir; enrop1 = e_op1; enrop2 = e_op2;
        enrio = e_io; enpc = e_pc; enmem = e_mem; seloper = op; selmux = mx;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycle(input logic r, input logic e_ir, input logic e_op1, input logic e_op2,
                            input logic e_io, input logic e_pc, input logic e_mem,
                            input logic [1:0] op, input logic [1:0] mx);
        applyStimulus(r, e_ir, e_op1, e_op2, e_io, e_pc, e_mem, op, mx);
        stepClock();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) loadMem(i, 8'h00);

        // Plain reset, then reset with every strobe high.
        runCycle(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        checking = 1;
        applyStimulus(1, 1, 1, 1, 1, 1, 1, 2'b00, 2'b00);
        checkOutput("reset mem_we follows enmem", 8'(bus.mem_we), 8'h01);
        stepClock();
        checkOutput("reset pc", 8'(pc), 8'h00);
        checkOutput("reset io_out", io_out, 8'h00);
        checkOutput("reset operacion", 8'(operacion), 8'h00);
        checkOutput("reset flags", {6'b0, flag_z, flag_c}, 8'h00);

        // SUM A=3, B=2: mem[3] = 0C + 05.
        loadMem(0, 8'h1A); loadMem(2, 8'h05); loadMem(3, 8'h0C);
        runCycle(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);   // fetch
        runCycle(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);   // decode
        runCycle(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01);   // OP1
        runCycle(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b10);   // OP2 / add
        runCycle(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11);   // write-back
        runCycle(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00);   // enpc
        checkOutput("sum mem[3]", tb_mem[3], 8'h11);
        checkOutput("sum pc", 8'(pc), 8'h01);
        checkOutput("sum flag_z", 8'(flag_z), 8'h00);
        checkOutput("sum flag_c", 8'(flag_c), 8'h00);

        // Subtract wrap: 03 - 05 = FE with borrow.
        loadMem(3, 8'h03); loadMem(2, 8'h05);
        runCycle(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01);
        runCycle(0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00);
        checkOutput("sub wrap result", bus.mem_wdata, 8'hFE);
        checkOutput("sub wrap flag_c", 8'(flag_c), expFlag(1));
        checkOutput("sub wrap flag_z", 8'(flag_z), 8'h00);
        stepClock();

        // MOV A=3 -> B=5, instruction fetched from address 1.
        loadMem(1, 8'h9D); loadMem(3, 8'h77);
        runCycle(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        checkOutput("mov operacion", 8'(operacion), 8'h02);
        runCycle(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10);
        checkOutput("mov mem_addr", 8'(bus.mem_addr), 8'h05);
        checkOutput("mov mem_wdata", bus.mem_wdata, 8'h77);
        stepClock();
        checkOutput("mov mem[5]", tb_mem[5], 8'h77);
        runCycle(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00);
        checkOutput("mov pc", 8'(pc), 8'h02);

        // OUT A=4 at address 7, then PC wraps to 0.
        for (int i = 0; i < 5; i++) runCycle(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00);
        checkOutput("pc before wrap", 8'(pc), 8'h07);
        loadMem(7, 8'hE0); loadMem(4, 8'hA5);
        runCycle(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        runCycle(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01);
        runCycle(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00);
        checkOutput("out io_out", io_out, 8'hA5);
        checkOutput("out pc wrap", 8'(pc), 8'h00);
        checkOutput("out operacion", 8'(operacion), 8'h03);

        // Simultaneous enir + enrio + enpc sharing one read of 42.
        loadMem(0, 8'h42);
        runCycle(0, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00);
        checkOutput("simul operacion", 8'(operacion), 8'h01);
        checkOutput("simul io_out", io_out, 8'h42);
        checkOutput("simul pc", 8'(pc), 8'h01);

        // Idle cycles hold all state.
        runCycle(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b10);
        runCycle(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b10);
        checkOutput("idle io_out", io_out, 8'h42);
        checkOutput("idle pc", 8'(pc), 8'h01);

        // Reset in the middle of an instruction; the next fetch reads address 0.
        runCycle(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        runCycle(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01);
        runCycle(1, 1, 1, 1, 1, 1, 1, 2'b00, 2'b01);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        checkOutput("post-reset fetch addr", 8'(bus.mem_addr), 8'h00);
        checkOutput("post-reset io_out", io_out, 8'h00);
        stepClock();
        checkOutput("post-reset operacion", 8'(operacion), 8'h01);
        runCycle(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 enir/enrop1/enrop2/enrio/enpc  in  1 each  load strobes for IR, OP1, OP2/result, IO register, PC.
REQ-004 enmem  in  1  memory write strobe.
REQ-005 seloper  in  2  ALU op: 00 add, 01 sub, 10 pass OP1, 11 pass operand.
REQ-006 selmux  in  2  address source: 00 PC, 01 IR[5:3] (A), 10 IR[2:0] (B), 11 IR[5:3] (A, write-back).
REQ-007 mem_rdata  in  8  asynchronous read data of external 8x8 memory at mem_addr.
REQ-008 mem_addr  out  3  memory address, combinational from selmux.
REQ-009 mem_wdata  out  8  memory write data.
REQ-010 mem_we  out  1  memory write enable, equal to enmem.
REQ-011 operacion  out  2  IR[7:6], opcode to control FSM.
REQ-012 io_out  out  8  IO register contents.
REQ-013 pc  out  3  program counter.
REQ-014 flag_z, flag_c  out  1 each  zero / carry-borrow flags (see Configuration).

Function
REQ-015 Instruction format SHALL be 8 bits: [7:6] opcode, [5:3] field A, [2:0] field B.
REQ-016 enir SHALL load IR from mem_rdata at the next edge; operacion SHALL follow IR with no further delay.
REQ-017 enrop1 SHALL load OP1 from mem_rdata at the next edge.
REQ-018 enrop2 SHALL load OP2 from mem_rdata and, on the same edge, load RES with ALU(OP1, mem_rdata, seloper) truncated to 8 bits.
REQ-019 Add/sub SHALL wrap modulo 256; seloper 10 yields OP1; 11 yields mem_rdata.
REQ-020 mem_wdata SHALL be OP1 when seloper=10, otherwise RES.
REQ-021 enrio SHALL load io_out from mem_rdata at the next edge.
REQ-022 enpc SHALL increment PC by 1 at the next edge, wrapping 7->0.
REQ-023 Strobes SHALL be independent; any combination asserted in one cycle SHALL all take effect on that edge, each reading the same mem_rdata.
REQ-024 Registers not strobed SHALL hold value; no strobe asserted SHALL leave all state unchanged.
REQ-025 Sequencing (per control FSM): fetch (selmux 00, enir) -> decode -> SUM/RES: OP1 (01) -> OP2 (10) -> write-back (11, enmem) -> enpc; MOV: OP1 (01) -> write to B (10, enmem, seloper 10) -> enpc; OUT: enrio (01) -> enpc.

Reset
REQ-026 rst high at an edge SHALL clear IR, OP1, OP2, RES, io_out, PC and flags to 0, overriding all strobes in that cycle.
REQ-027 Reset mid-instruction SHALL abandon it; after release, the first fetch SHALL address 0.
REQ-028 mem_we SHALL equal enmem even during reset; the control FSM is responsible for deasserting enmem.

Configuration
REQ-029 Macro DATAPATH_FLAGS_EN defined: on every enrop2 edge flag_z <= (ALU result==0), flag_c <= carry-out for add, borrow for sub, 0 for pass ops.
REQ-030 Macro not defined: no flag registers; flag_z and flag_c SHALL be constant 0.

Verification
REQ-031 Reset: drive strobes high with rst=1 for one edge -> pc=0, io_out=0, operacion=00, flags 0.
REQ-032 SUM: mem={0:8'h1A (SUM A=3,B=2), 2:8'h05, 3:8'h0C}; run FSM sequence -> mem[3]=8'h11, pc=1, flag_z=0, flag_c=0.
REQ-033 RES wrap: OP1=8'h03, operand 8'h05, seloper 01 -> RES=8'hFE; with DATAPATH_FLAGS_EN flag_c=1.
REQ-034 MOV: IR=8'h9D (A=3,B=5), mem[3]=8'h77 -> mem[5]=8'h77, mem_addr=5 during write cycle.
REQ-035 OUT + PC wrap: pc=7, OUT A=4, mem[4]=8'hA5 -> io_out=8'hA5, pc=0 after enpc.
REQ-036 Simultaneous strobes: enir, enrio, enpc in one cycle with mem_rdata=8'h42 -> IR=8'h42, io_out=8'h42, pc incremented once.
